// File: rtl/frac_clk_gen_pkg.sv
// Shared types and default constants for the fractional clock-enable generator.
// Optional phase-align input is enabled by defining FRAC_CLK_GEN_SYNC_EN.
package frac_clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int              DEF_CHANNELS      = 2;
  localparam int              DEF_ACC_WIDTH     = 32;
  localparam longint unsigned DEF_DEFAULT_INC   = 64'd204011;
  localparam int              DEF_SETTLE_CYCLES = 1024;
  localparam int              SETTLE_CNT_W      = 16;

  // Channel-select width, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frac_clk_gen_chan.sv
// One phase-accumulator channel: active/pending increment, registered carry and MSB.
// With FRAC_CLK_GEN_SYNC_EN defined, a sync strobe zeroes the accumulator in RUN.
module frac_clk_gen_chan
  import frac_clk_gen_pkg::*;
#(
  parameter int                   ACC_WIDTH = DEF_ACC_WIDTH,
  parameter logic [ACC_WIDTH-1:0] RESET_INC = ACC_WIDTH'(DEF_DEFAULT_INC)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
`ifdef FRAC_CLK_GEN_SYNC_EN
  input  logic                 sync,
`endif
  input  logic                 load,
  input  logic [ACC_WIDTH-1:0] load_data,
  output logic                 ce,
  output logic                 clk_sq
);

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] active_inc_q, active_inc_d;
  logic [ACC_WIDTH-1:0] pending_inc_q, pending_inc_d;
  logic                 pending_valid_q, pending_valid_d;
  logic                 ce_q, ce_d;
  logic                 sq_q, sq_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 apply;

  // Outside RUN the increment is applied every cycle, so any load is in effect
  // by the first accumulation; in RUN it only changes on a carry edge.
  always_comb begin
    sum             = {1'b0, acc_q} + {1'b0, active_inc_q};
    acc_d           = '0;
    ce_d            = 1'b0;
    sq_d            = 1'b0;
    apply           = 1'b1;
    active_inc_d    = active_inc_q;
    pending_inc_d   = pending_inc_q;
    pending_valid_d = pending_valid_q;

    if (run) begin
`ifdef FRAC_CLK_GEN_SYNC_EN
      if (sync) begin
        acc_d = '0;
        ce_d  = 1'b0;
        sq_d  = 1'b0;
        apply = 1'b1;
      end else
`endif
      begin
        acc_d = sum[ACC_WIDTH-1:0];
        ce_d  = sum[ACC_WIDTH];
        sq_d  = sum[ACC_WIDTH-1];
        apply = sum[ACC_WIDTH];
      end
    end

    if (load && apply) begin
      active_inc_d    = load_data;
      pending_valid_d = 1'b0;
    end else if (apply && pending_valid_q) begin
      active_inc_d    = pending_inc_q;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_inc_d   = load_data;
      pending_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q           <= '0;
      active_inc_q    <= RESET_INC;
      pending_inc_q   <= '0;
      pending_valid_q <= 1'b0;
      ce_q            <= 1'b0;
      sq_q            <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      active_inc_q    <= active_inc_d;
      pending_inc_q   <= pending_inc_d;
      pending_valid_q <= pending_valid_d;
      ce_q            <= ce_d;
      sq_q            <= sq_d;
    end
  end

  assign ce     = ce_q;
  assign clk_sq = sq_q;

endmodule

// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator with IDLE/SETTLE/RUN lock FSM.
// Define FRAC_CLK_GEN_SYNC_EN to add the sync_in phase-align strobe.
module frac_clk_gen
  import frac_clk_gen_pkg::*;
#(
  parameter int              CHANNELS      = DEF_CHANNELS,
  parameter int              ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter longint unsigned DEFAULT_INC   = DEF_DEFAULT_INC,
  parameter int              SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int             SEL_W         = sel_width(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc_load,
  input  logic [SEL_W-1:0]     inc_sel,
  input  logic [ACC_WIDTH-1:0] inc_data,
`ifdef FRAC_CLK_GEN_SYNC_EN
  input  logic                 sync_in,
`endif
  output logic [CHANNELS-1:0]  ce,
  output logic [CHANNELS-1:0]  clk_sq,
  output logic                 locked
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ACC_WIDTH-1:0]    RESET_INC   = ACC_WIDTH'(DEFAULT_INC);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                    run;

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      IDLE: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = RUN;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign run    = (state_q == RUN);
  assign locked = run;

  // Out-of-range selects match no channel, so such loads are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic load_hit;
    assign load_hit = inc_load && (inc_sel == SEL_W'(i));

    frac_clk_gen_chan #(
      .ACC_WIDTH (ACC_WIDTH),
      .RESET_INC (RESET_INC)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
`ifdef FRAC_CLK_GEN_SYNC_EN
      .sync      (sync_in),
`endif
      .load      (load_hit),
      .load_data (inc_data),
      .ce        (ce[i]),
      .clk_sq    (clk_sq[i])
    );
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// Self-checking bench for frac_clk_gen: arithmetic reference model plus directed
// literal checks and randomized increment loads, resets and (optional) sync strobes.
module tb_frac_clk_gen;

  localparam int W   = 8;
  localparam int CH  = 3;
  localparam int SC  = 4;
  localparam int INC = 64;
  localparam longint MOD = 64'd1 << W;

  logic          clk = 1'b0;
  logic          reset;
  logic          inc_load;
  logic [1:0]    inc_sel;
  logic [W-1:0]  inc_data;
  logic          sync_in;
  logic [CH-1:0] ce;
  logic [CH-1:0] clk_sq;
  logic          locked;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  frac_clk_gen #(
    .CHANNELS      (CH),
    .ACC_WIDTH     (W),
    .DEFAULT_INC   (INC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .inc_load (inc_load),
    .inc_sel  (inc_sel),
    .inc_data (inc_data),
`ifdef FRAC_CLK_GEN_SYNC_EN
    .sync_in  (sync_in),
`endif
    .ce       (ce),
    .clk_sq   (clk_sq),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  // Reference model: edges since reset decide the lock state; each channel is
  // a plain integer phase accumulator modulo 2^W.
  longint m_acc [CH];
  longint m_act [CH];
  longint m_pend[CH];
  bit     m_pv  [CH];
  bit [CH-1:0] m_ce, m_sq;
  bit     m_locked;
  int     m_edges;
  bit     m_running, m_sync, m_ld, m_apply;
  longint m_sum;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_edges  = 0;
      m_locked = 0;
      m_ce     = '0;
      m_sq     = '0;
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_act[c] = INC; m_pend[c] = 0; m_pv[c] = 0;
      end
    end else begin
      m_running = (m_edges >= SC + 1);
`ifdef FRAC_CLK_GEN_SYNC_EN
      m_sync = m_running && (sync_in === 1'b1);
`else
      m_sync = 1'b0;
`endif
      for (int c = 0; c < CH; c++) begin
        m_ld = inc_load && (int'(inc_sel) == c);
        if (m_running && !m_sync) begin
          m_sum    = m_acc[c] + m_act[c];
          m_ce[c]  = (m_sum >= MOD);
          m_acc[c] = m_sum % MOD;
          m_apply  = m_ce[c];
        end else begin
          m_acc[c] = 0;
          m_ce[c]  = 0;
          m_apply  = 1;
        end
        m_sq[c] = (m_acc[c] >= MOD / 2);
        if (m_ld && m_apply) begin
          m_act[c] = inc_data; m_pv[c] = 0;
        end else if (m_apply && m_pv[c]) begin
          m_act[c] = m_pend[c]; m_pv[c] = 0;
        end else if (m_ld) begin
          m_pend[c] = inc_data; m_pv[c] = 1;
        end
      end
      if (m_edges < 1000000) m_edges++;
      m_locked = (m_edges >= SC + 1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  // Cycles until ce[ch] is seen, bounded by limit.
  task automatic gapCe(input int ch, input int limit, output int gap);
    gap = 0;
    do begin
      nextCycle();
      gap++;
    end while (!ce[ch] && gap < limit);
  endtask

  task automatic applyStimulus();
    int pick;
    inc_load = ($urandom_range(0, 5) == 0);
    inc_sel  = 2'($urandom_range(0, 3));
    pick     = $urandom_range(0, 7);
    case (pick)
      0: inc_data = 8'd0;
      1: inc_data = 8'd16;
      2: inc_data = 8'd32;
      3: inc_data = 8'd64;
      4: inc_data = 8'd128;
      5: inc_data = 8'd255;
      default: inc_data = 8'($urandom_range(1, 255));
    endcase
`ifdef FRAC_CLK_GEN_SYNC_EN
    sync_in = ($urandom_range(0, 40) == 0);
`endif
  endtask

  // Every-cycle comparison against the model, sampled 1 time unit after the edge.
  initial begin
    @(posedge clk);
    while (!done) begin
      @(posedge clk);
      #1;
      if (!done) checkOutput("model", {29'd0, ce, clk_sq, locked}, {29'd0, m_ce, m_sq, m_locked});
    end
  end

  initial begin
    int g, ce_hits, sq_hits;
    logic [7:0] ce_pat, sq_pat;
    reset = 1'b1; inc_load = 1'b0; inc_sel = '0; inc_data = '0; sync_in = 1'b0;
    repeat (3) nextCycle();
    checkOutput("reset_ce", {29'd0, ce}, 32'd0);
    checkOutput("reset_sq", {29'd0, clk_sq}, 32'd0);
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);

    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      nextCycle();
      if (k == 4) checkOutput("locked_early", {31'd0, locked}, 32'd0);
      if (k == 5) checkOutput("locked_at_5", {31'd0, locked}, 32'd1);
    end

    ce_pat = 8'b1000_1000;
    sq_pat = 8'b0110_0110;
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      checkOutput("ce0_pattern", {31'd0, ce[0]}, {31'd0, ce_pat[k]});
      checkOutput("sq0_pattern", {31'd0, clk_sq[0]}, {31'd0, sq_pat[k]});
    end

    // Mid-period load of 32: current period finishes, then 8-cycle periods.
    nextCycle();
    inc_load = 1'b1; inc_sel = 2'd0; inc_data = 8'd32;
    nextCycle();
    inc_load = 1'b0;
    gapCe(0, 20, g); checkOutput("finish_old_period", g, 2);
    gapCe(0, 20, g); checkOutput("slow_period_a", g, 8);
    gapCe(0, 20, g); checkOutput("slow_period_b", g, 8);

    // Load on the carry edge bypasses pending.
    repeat (7) nextCycle();
    inc_load = 1'b1; inc_sel = 2'd0; inc_data = 8'd128;
    nextCycle();
    checkOutput("bypass_edge_ce", {31'd0, ce[0]}, 32'd1);
    inc_load = 1'b0;
    gapCe(0, 20, g); checkOutput("bypass_period_a", g, 2);
    gapCe(0, 20, g); checkOutput("bypass_period_b", g, 2);

    // Zero increment on the carry edge freezes the channel.
    nextCycle();
    inc_load = 1'b1; inc_sel = 2'd0; inc_data = 8'd0;
    nextCycle();
    checkOutput("zero_edge_ce", {31'd0, ce[0]}, 32'd1);
    inc_load = 1'b0;
    ce_hits = 0; sq_hits = 0;
    repeat (20) begin
      nextCycle();
      ce_hits += int'(ce[0]);
      sq_hits += int'(clk_sq[0]);
    end
    checkOutput("frozen_ce", ce_hits, 0);
    checkOutput("frozen_sq", sq_hits, 0);

    // Out-of-range select must not disturb channel 1.
    gapCe(1, 10, g);
    inc_load = 1'b1; inc_sel = 2'd3; inc_data = 8'd1;
    nextCycle();
    inc_load = 1'b0;
    gapCe(1, 10, g); checkOutput("sel3_period_a", 1 + g, 4);
    gapCe(1, 10, g); checkOutput("sel3_period_b", g, 4);

    // Asynchronous reset mid-RUN, then re-lock.
    reset = 1'b1;
    #1;
    checkOutput("midreset_ce", {29'd0, ce}, 32'd0);
    checkOutput("midreset_sq", {29'd0, clk_sq}, 32'd0);
    checkOutput("midreset_locked", {31'd0, locked}, 32'd0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    g = 0;
    do begin
      nextCycle();
      g++;
    end while (!locked && g < 20);
    checkOutput("relock_cycles", g, SC + 1);

    for (int n = 0; n < 3000; n++) begin
      nextCycle();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      applyStimulus();
    end

    inc_load = 1'b0;
    sync_in  = 1'b0;
    nextCycle();
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
